iter_shifter: RTL and testbench
===============================

Name: iter_shifter

Overview:
- Parametrised, multi-cycle successor to the lab's combinational 16-bit shifter.
- Shifts or rotates a WIDTH-bit operand by up to STEP bit positions per clock.
- Uses valid/ready handshakes on input and output.
- Reports carry-out, signed overflow and zero flags.
- Sits between the ALU operand registers and the result writeback, so long shifts trade latency for area.

Parameters:
WIDTH, 16, operand/result width; power of 2, >= 4
AMT_W, 16, shift-amount port width
STEP, 4, max bit positions shifted per SHIFT cycle; 1 <= STEP <= WIDTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand/amount/mode valid
in_ready  output  1  block can accept a request
a  input  WIDTH  operand
amt  input  AMT_W  shift amount, unsigned
mode  input  3  000 LSL, 001 ASL, 010 LSR, 011 ASR, 100 ROL, 101 ROR, 110/111 illegal
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
x  output  WIDTH  result
carry  output  1  last bit shifted/rotated out
ovf  output  1  signed overflow (ASL only)
zero  output  1  x == 0
err  output  1  illegal mode

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state IDLE, in_ready=1, out_valid=0, x=0, carry=0, ovf=0, zero=0, err=0.
- Reset mid-operation: the request is discarded, with no output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch a, mode and effective amount N.
  - Go to SHIFT if N>0, else DONE.
- Effective amount N:
  - Shifts: N = min(amt, WIDTH).
  - Rotates: N = amt mod WIDTH.
  - Illegal mode: N = 0.
- SHIFT:
  - Each cycle, move by k = min(STEP, remaining).
  - Fill bits: LSL/ASL fill 0 at LSB; LSR fills 0 at MSB; ASR fills the original a[MSB]; rotates wrap around.
  - Go to DONE when remaining reaches 0.
  - Takes ceil(N/STEP) cycles.
- Latency:
  - out_valid rises 1+ceil(N/STEP) cycles after the acceptance edge.
  - N=0 gives 1 cycle, with x=a.
- DONE:
  - out_valid=1, in_ready=0.
  - x and all flags are held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
  - A new request is accepted no earlier than the following cycle.
- carry:
  - N=0 gives 0.
  - Shifts give the last bit pushed out.
  - LSL/ASL/LSR with amt>WIDTH give 0.
  - ASR with amt>=WIDTH gives a[MSB].
  - ROL gives x[0]; ROR gives x[MSB].
- ovf:
  - ASL only; 0 for all other modes.
  - N<WIDTH: 1 iff a[MSB:MSB-N] are not all equal.
  - N>=WIDTH: 1 iff a != 0.
- zero: (x==0), registered with x.
- err:
  - Illegal mode gives err=1, x=a, carry=0, ovf=0.
  - Normal handshake and 1-cycle latency apply.
- Inputs a, amt and mode are ignored outside the IDLE accept cycle.
- Back-pressure: out_ready held low keeps DONE indefinitely, and in_ready stays 0.

Test Plan:
- WIDTH=16, STEP=4, LSL a=16'h8001 amt=3 -> x=16'h0008, carry=0 (last bit out a[13]=0), ovf=0, out_valid 2 cycles after accept.
- ASR a=16'h8000 amt=20 -> N=16, 4 SHIFT cycles, x=16'hFFFF, carry=1, ovf=0; same operand with LSR amt=20 -> x=0, zero=1, carry=0.
- ASL a=16'h4000 amt=1 -> x=16'h8000, ovf=1; ASL a=16'hC000 amt=1 -> x=16'h8000, ovf=0.
- ROR a=16'h0001 amt=17 -> N=1, x=16'h8000, carry=1; ROL amt=16 -> N=0, x=a, carry=0, 1-cycle latency.
- Hold out_ready=0 for 5 cycles in DONE -> x and flags stable, in_ready=0, second in_valid ignored; mode=3'b111 -> err=1, x=a.
- Assert rst_n=0 during SHIFT -> out_valid=0 and in_ready=1 immediately (asynchronous); next request completes normally.

Source files
------------

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter/rotator with valid/ready handshakes.
// Moves a WIDTH-bit operand by up to STEP bit positions per clock, so long
// shifts take more cycles instead of needing a full barrel shifter.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  request handshake; a, amt, mode sampled on accept
//   a                    operand
//   amt                  unsigned shift amount
//   mode                 000 LSL, 001 ASL, 010 LSR, 011 ASR, 100 ROL, 101 ROR,
//                        110/111 illegal
//   out_valid/out_ready  result handshake; result held stable until taken
//   x                    result
//   carry                last bit shifted/rotated out
//   ovf                  signed overflow (ASL only)
//   zero                 x == 0
//   err                  illegal mode (x passes a through)
module iter_shifter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 16,
  parameter int unsigned STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             err
);

  // Counter wide enough to hold WIDTH itself.
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned LW = $clog2(WIDTH);

  localparam logic [2:0] ModeLsl = 3'b000;
  localparam logic [2:0] ModeAsl = 3'b001;
  localparam logic [2:0] ModeLsr = 3'b010;
  localparam logic [2:0] ModeAsr = 3'b011;
  localparam logic [2:0] ModeRol = 3'b100;
  localparam logic [2:0] ModeRor = 3'b101;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_x, w_x_d;
  logic [2:0]       r_mode, w_mode_d;
  logic [CW-1:0]    r_rem, w_rem_d;
  logic             r_carry, w_carry_d;
  logic             r_ovf, w_ovf_d;
  logic             r_zero, w_zero_d;
  logic             r_err, w_err_d;
  // Forces carry to 0 when a plain shift overshoots the operand width.
  logic             r_cclr, w_cclr_d;

  // Accept-time decode of the incoming request.
  logic [31:0]             w_amt_ext;
  logic                    w_is_shift;
  logic                    w_is_rot;
  logic                    w_amt_ge;
  logic                    w_amt_gt;
  logic [CW-1:0]           w_n;
  logic [CW-1:0]           w_ovf_sh;
  logic signed [WIDTH-1:0] w_top;
  logic                    w_ovf_in;

  always_comb begin
    w_amt_ext  = 32'(amt);
    w_is_shift = (mode == ModeLsl) || (mode == ModeAsl) || (mode == ModeLsr) ||
                 (mode == ModeAsr);
    w_is_rot   = (mode == ModeRol) || (mode == ModeRor);
    w_amt_ge   = (w_amt_ext >= WIDTH);
    w_amt_gt   = (w_amt_ext > WIDTH);

    w_n = '0;
    if (w_is_shift) begin
      w_n = w_amt_ge ? CW'(WIDTH) : CW'(w_amt_ext);
    end else if (w_is_rot) begin
      w_n = CW'(w_amt_ext[LW-1:0]);
    end

    // ASL overflows when the top N+1 bits of a disagree: sign-shifting them
    // down to the LSBs must give all zeros or all ones otherwise.
    w_ovf_sh = CW'(WIDTH - 1) - w_n;
    w_top    = $signed(a) >>> w_ovf_sh;
    w_ovf_in = 1'b0;
    if (mode == ModeAsl) begin
      if (w_amt_ge) begin
        w_ovf_in = (a != '0);
      end else begin
        w_ovf_in = !((w_top == '0) || (w_top == '1));
      end
    end
  end

  // One SHIFT step of k = min(STEP, remaining) positions.
  logic [CW-1:0]    w_k;
  logic [CW-1:0]    w_kl;
  logic [CW-1:0]    w_km1;
  logic [WIDTH-1:0] w_sh;
  logic [WIDTH-1:0] w_out;

  always_comb begin
    w_k   = (r_rem < CW'(STEP)) ? r_rem : CW'(STEP);
    w_kl  = CW'(WIDTH) - w_k;
    w_km1 = w_k - CW'(1);
    w_sh  = r_x;
    w_out = '0;
    case (r_mode)
      ModeLsl, ModeAsl: begin
        w_sh  = r_x << w_k;
        w_out = r_x >> w_kl;
      end
      ModeLsr: begin
        w_sh  = r_x >> w_k;
        w_out = r_x >> w_km1;
      end
      ModeAsr: begin
        // r_x[MSB] still equals the original a[MSB], so it is the fill bit.
        w_sh  = $signed(r_x) >>> w_k;
        w_out = r_x >> w_km1;
      end
      ModeRol: begin
        w_sh  = (r_x << w_k) | (r_x >> w_kl);
        w_out = r_x >> w_kl;
      end
      ModeRor: begin
        w_sh  = (r_x >> w_k) | (r_x << w_kl);
        w_out = r_x >> w_km1;
      end
      default: begin
        w_sh  = r_x;
        w_out = '0;
      end
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_x_d     = r_x;
    w_mode_d  = r_mode;
    w_rem_d   = r_rem;
    w_carry_d = r_carry;
    w_ovf_d   = r_ovf;
    w_zero_d  = r_zero;
    w_err_d   = r_err;
    w_cclr_d  = r_cclr;

    case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_x_d     = a;
          w_mode_d  = mode;
          w_rem_d   = w_n;
          w_carry_d = 1'b0;
          w_ovf_d   = w_ovf_in;
          w_err_d   = !(w_is_shift || w_is_rot);
          w_cclr_d  = w_amt_gt && (mode != ModeAsr) && w_is_shift;
          w_zero_d  = (a == '0);
          w_state_d = (w_n != '0) ? StShift : StDone;
        end
      end
      StShift: begin
        w_x_d     = w_sh;
        w_carry_d = w_out[0] & ~r_cclr;
        w_zero_d  = (w_sh == '0);
        w_rem_d   = r_rem - w_k;
        if (w_rem_d == '0) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_x     <= '0;
      r_mode  <= '0;
      r_rem   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_err   <= 1'b0;
      r_cclr  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_x     <= w_x_d;
      r_mode  <= w_mode_d;
      r_rem   <= w_rem_d;
      r_carry <= w_carry_d;
      r_ovf   <= w_ovf_d;
      r_zero  <= w_zero_d;
      r_err   <= w_err_d;
      r_cclr  <= w_cclr_d;
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign x         = r_x;
  assign carry     = r_carry;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign err       = r_err;

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter (WIDTH=16, AMT_W=16, STEP=4).
// The driver pushes the model's expected result on every accepted request;
// the monitor pops and compares whenever the DUT hands a result over.
module tb_iter_shifter;

  typedef struct {
    logic [15:0] x;
    logic        c;
    logic        o;
    logic        z;
    logic        e;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] amt = '0;
  logic [2:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] x;
  logic        carry, ovf, zero, err;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   hold = 1'b0;
  bit   prev_ov = 1'b0;
  exp_t sbq[$];
  logic [19:0] snap;

  iter_shifter #(.WIDTH(16), .AMT_W(16), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .amt       (amt),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .carry     (carry),
    .ovf       (ovf),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Consumer: random back-pressure unless a test asks for a hard stall.
  always @(posedge clk) begin
    #1;
    if (hold) out_ready = 1'b0;
    else out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: whole-amount arithmetic on 32-bit integers.
  function automatic exp_t model(input logic [15:0] fa, input logic [15:0] famt,
                                 input logic [2:0] fm);
    exp_t        e;
    int          n;
    int unsigned av;
    int unsigned am;
    int unsigned r;
    int          s;
    av = {16'h0, fa};
    am = {16'h0, famt};
    s  = int'($signed(fa));
    n  = 0;
    e.c = 1'b0;
    e.o = 1'b0;
    e.e = 1'b0;
    if (fm > 3'd5) e.e = 1'b1;
    else if (fm >= 3'd4) n = int'(am % 16);
    else n = (am > 16) ? 16 : int'(am);
    case (fm)
      3'd0, 3'd1: begin
        r = (av << n) & 32'hFFFF;
        if (n > 0 && am <= 16) e.c = ((av >> (16 - n)) & 1) != 0;
      end
      3'd2: begin
        r = av >> n;
        if (n > 0 && am <= 16) e.c = ((av >> (n - 1)) & 1) != 0;
      end
      3'd3: begin
        r = 32'(s >>> n) & 32'hFFFF;
        if (n > 0) e.c = ((s >>> (n - 1)) & 1) != 0;
      end
      3'd4: begin
        r = ((av << n) | (av >> (16 - n))) & 32'hFFFF;
        e.c = (n > 0) && ((r & 1) != 0);
      end
      3'd5: begin
        r = ((av >> n) | (av << (16 - n))) & 32'hFFFF;
        e.c = (n > 0) && (((r >> 15) & 1) != 0);
      end
      default: r = av;
    endcase
    if (fm == 3'd1) begin
      if (n >= 16) e.o = (fa != 0);
      else for (int i = 15 - n; i <= 15; i++) if (fa[i] != fa[15]) e.o = 1'b1;
    end
    e.x   = r[15:0];
    e.z   = (r[15:0] == 16'h0);
    e.lat = (n + 3) / 4;
    e.acc = 0;
    return e;
  endfunction

  // Issue one request; the expectation is queued as it is presented.
  task automatic send(input logic [15:0] ta, input logic [15:0] tamt, input logic [2:0] tm);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0, expected 1 within 200 cycles");
      return;
    end
    a = ta;
    amt = tamt;
    mode = tm;
    in_valid = 1'b1;
    e = model(ta, tamt, tm);
    // Cycle 1 is the period opened by the acceptance edge; out_valid is due
    // in cycle 1+ceil(N/STEP), i.e. at period index acc+lat.
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    amt = 16'($urandom);
    mode = 3'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("drain_queue_empty", 32'(sbq.size()), 32'd0);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_ov) begin
          if (sbq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_output: got x=%0h with no request pending", x);
          end else begin
            check("latency", 32'(cyc), 32'(sbq[0].acc + sbq[0].lat));
          end
          snap = {x, carry, ovf, zero, err};
        end else begin
          check("done_hold_stable", {12'h0, x, carry, ovf, zero, err}, {12'h0, snap});
        end
        check("in_ready_low_in_done", {31'h0, in_ready}, 32'd0);
        if (out_ready && sbq.size() != 0) begin
          e = sbq.pop_front();
          check("x", {16'h0, x}, {16'h0, e.x});
          check("flags_c_o_z_e", {28'h0, carry, ovf, zero, err}, {28'h0, e.c, e.o, e.z, e.e});
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    #12;
    check("reset_in_ready", {31'h0, in_ready}, 32'd1);
    check("reset_out_valid", {31'h0, out_valid}, 32'd0);
    check("reset_outputs", {12'h0, x, carry, ovf, zero, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(16'h8001, 16'd3, 3'b000);
    send(16'h8000, 16'd20, 3'b011);
    send(16'h8000, 16'd20, 3'b010);
    send(16'h4000, 16'd1, 3'b001);
    send(16'hC000, 16'd1, 3'b001);
    send(16'h0001, 16'd17, 3'b101);
    send(16'h0001, 16'd16, 3'b100);
    send(16'h1234, 16'd5, 3'b111);
    send(16'hA5C3, 16'd16, 3'b000);
    send(16'h0F00, 16'd40, 3'b001);
    drain();

    // Back-pressure: result held 5+ cycles, competing request ignored.
    hold = 1'b1;
    send(16'h8421, 16'd7, 3'b010);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("hold_out_valid_seen", {31'h0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      a = 16'hFFFF;
      amt = 16'd2;
      mode = 3'b000;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    hold = 1'b0;
    drain();

    // Asynchronous reset during SHIFT discards the request.
    send(16'h8000, 16'd16, 3'b011);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("async_rst_in_ready", {31'h0, in_ready}, 32'd1);
    check("async_rst_x", {16'h0, x}, 32'd0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h00F0, 16'd6, 3'b100);
    drain();

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      logic [15:0] ra, ram;
      logic [2:0]  rm;
      ra = 16'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 16'h0000;
        1: ra = 16'hFFFF;
        2: ra = 16'h8000;
        default: ;
      endcase
      ram = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      rm = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      send(ra, ram, rm);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
